apb_req_master: RTL and testbench

- Bridges a simple valid/ready request/response port to an APB4 master port.
- Issues exactly one APB transfer per accepted request and drives the SETUP and ACCESS phases from registered state.
- Holds the slave's answer until the requester consumes it.
- Sits directly upstream of APB register slaves; single outstanding transfer, no reordering.

---
 rtl/apb_pkg.sv | 30 +++
 rtl/apb_req_master.sv | 121 ++++++++++++
 tb/tb_apb_req_master.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_pkg.sv
// Shared types for the request-to-APB4 master bridge.
// Holds the FSM state enum, request/response bundles and APB widths.
package apb_pkg;

    localparam int PROT_W = 3;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              write;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] strb;
        logic [PROT_W-1:0] prot;
    } req_t;

    typedef struct packed {
        logic [DATA_W-1:0] rdata;
        logic              err;
    } resp_t;

endpackage

// File: rtl/apb_req_master.sv
// Bridges a valid/ready request/response port to an APB4 master port.
// Ports: pclk_i/preset_i (sync, active-high); req_* request channel;
// resp_* response channel; busy_o; p* APB4 master signals.
module apb_req_master
    import apb_pkg::*;
#(
    parameter  int ADDR_WIDTH = 32,
    parameter  int DATA_WIDTH = 32,
    localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  pclk_i,
    input  logic                  preset_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic                  req_write_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    input  logic [STRB_WIDTH-1:0] req_strb_i,
    input  logic [PROT_W-1:0]     req_prot_i,
    output logic                  resp_valid_o,
    input  logic                  resp_ready_i,
    output logic [DATA_WIDTH-1:0] resp_rdata_o,
    output logic                  resp_err_o,
    output logic                  busy_o,
    output logic [ADDR_WIDTH-1:0] paddr_o,
    output logic [PROT_W-1:0]     pprot_o,
    output logic                  psel_o,
    output logic                  penable_o,
    output logic                  pwrite_o,
    output logic [DATA_WIDTH-1:0] pwdata_o,
    output logic [STRB_WIDTH-1:0] pstrb_o,
    input  logic                  pready_i,
    input  logic [DATA_WIDTH-1:0] prdata_i,
    input  logic                  pslverr_i
);

    if (DATA_WIDTH != DATA_W) begin : g_bad_data
        $fatal(1, "apb_req_master: DATA_WIDTH must be 32");
    end
    if (ADDR_WIDTH > ADDR_W || ADDR_WIDTH < 3) begin : g_bad_addr
        $fatal(1, "apb_req_master: ADDR_WIDTH must be 3..32");
    end

    state_t state;
    req_t   req_q;
    resp_t  resp_q;
    logic   req_ready_q;
    logic   psel_q;
    logic   penable_q;
    logic   resp_valid_q;
    logic   busy_q;

    // Every output is a flop (or a slice of one).
    always_ff @(posedge pclk_i) begin
        if (preset_i) begin
            state        <= IDLE;
            req_q        <= '0;
            resp_q       <= '0;
            req_ready_q  <= 1'b1;
            psel_q       <= 1'b0;
            penable_q    <= 1'b0;
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid_i) begin
                        // Word-aligned address; reads carry no data/strobes.
                        req_q.addr  <= ADDR_W'({req_addr_i[ADDR_WIDTH-1:2],
                                                2'b00});
                        req_q.write <= req_write_i;
                        req_q.wdata <= req_write_i ? req_wdata_i : '0;
                        req_q.strb  <= req_write_i ? req_strb_i : '0;
                        req_q.prot  <= req_prot_i;
                        req_ready_q <= 1'b0;
                        psel_q      <= 1'b1;
                        busy_q      <= 1'b1;
                        state       <= SETUP;
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    state     <= ACCESS;
                end
                ACCESS: begin
                    if (pready_i) begin
                        resp_q.err   <= pslverr_i;
                        resp_q.rdata <= req_q.write ? '0 : prdata_i;
                        psel_q       <= 1'b0;
                        penable_q    <= 1'b0;
                        resp_valid_q <= 1'b1;
                        state        <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready_i) begin
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                        busy_q       <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready_o  = req_ready_q;
    assign resp_valid_o = resp_valid_q;
    assign resp_rdata_o = resp_q.rdata;
    assign resp_err_o   = resp_q.err;
    assign busy_o       = busy_q;
    assign paddr_o      = req_q.addr[ADDR_WIDTH-1:0];
    assign pprot_o      = req_q.prot;
    assign psel_o       = psel_q;
    assign penable_o    = penable_q;
    assign pwrite_o     = req_q.write;
    assign pwdata_o     = req_q.wdata;
    assign pstrb_o      = req_q.strb;

endmodule

// File: tb/tb_apb_req_master.sv
// Self-checking bench for apb_req_master: directed cases plus random
// transactions against a word-level memory reference model.
module tb_apb_req_master;

    logic        clk = 1'b0;
    logic        preset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_write;
    logic [31:0] req_wdata;
    logic [3:0]  req_strb;
    logic [2:0]  req_prot;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        busy;
    logic [31:0] paddr;
    logic [2:0]  pprot;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;

    int n_cmp = 0;
    int n_err = 0;

    // Slave storage (written from the APB pins) and reference storage
    // (written from the requests as issued).
    logic [31:0] slave_mem [16];
    logic [31:0] ref_mem   [16];

    always #5 clk = ~clk;

    apb_req_master dut (
        .pclk_i       (clk),
        .preset_i     (preset),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_addr_i   (req_addr),
        .req_write_i  (req_write),
        .req_wdata_i  (req_wdata),
        .req_strb_i   (req_strb),
        .req_prot_i   (req_prot),
        .resp_valid_o (resp_valid),
        .resp_ready_i (resp_ready),
        .resp_rdata_o (resp_rdata),
        .resp_err_o   (resp_err),
        .busy_o       (busy),
        .paddr_o      (paddr),
        .pprot_o      (pprot),
        .psel_o       (psel),
        .penable_o    (penable),
        .pwrite_o     (pwrite),
        .pwdata_o     (pwdata),
        .pstrb_o      (pstrb),
        .pready_i     (pready),
        .prdata_i     (prdata),
        .pslverr_i    (pslverr)
    );

    // APB slave write side: commits on a completed in-range write.
    always @(posedge clk) begin
        if (!preset && psel && penable && pready && pwrite && paddr < 32'h40) begin
            for (int b = 0; b < 4; b++)
                if (pstrb[b])
                    slave_mem[paddr[5:2]][8*b +: 8] <= pwdata[8*b +: 8];
        end
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] err_word(input logic [31:0] a);
        return 32'hBAD0_0000 | {16'h0, a[15:0]};
    endfunction

    task automatic run_txn(input logic [31:0] addr, input logic wr,
                           input logic [31:0] wd, input logic [3:0] strb,
                           input logic [2:0] prot, input int waits,
                           input int hold);
        logic [31:0] al;
        logic [3:0]  idx;
        logic        err;
        logic [31:0] exp_rd;
        logic [31:0] exp_wd;
        logic [3:0]  exp_strb;
        al       = addr & ~32'h3;
        idx      = al[5:2];
        err      = (al >= 32'h40);
        exp_wd   = wr ? wd : 32'h0;
        exp_strb = wr ? strb : 4'h0;
        if (wr) begin
            exp_rd = 32'h0;
            if (!err)
                for (int b = 0; b < 4; b++)
                    if (strb[b]) ref_mem[idx][8*b +: 8] = wd[8*b +: 8];
        end else begin
            exp_rd = err ? err_word(al) : ref_mem[idx];
        end

        req_valid = 1'b1;
        req_addr  = addr;
        req_write = wr;
        req_wdata = wr ? wd : $urandom;
        req_strb  = wr ? strb : 4'($urandom);
        req_prot  = prot;
        pready    = 1'($urandom);
        pslverr   = 1'($urandom);
        prdata    = $urandom;
        check("idle_req_ready", req_ready, 1);

        // SETUP
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
        check("setup_psel", psel, 1);
        check("setup_penable", penable, 0);
        check("setup_paddr", paddr, al);
        check("setup_pwrite", pwrite, wr);
        check("setup_pwdata", pwdata, exp_wd);
        check("setup_pstrb", pstrb, exp_strb);
        check("setup_pprot", pprot, prot);
        check("setup_resp_valid", resp_valid, 0);
        check("setup_busy", busy, 1);
        check("setup_req_ready", req_ready, 0);
        pready  = 1'($urandom);
        pslverr = 1'($urandom);
        prdata  = $urandom;

        // ACCESS, waits+1 cycles
        for (int w = 0; w <= waits; w++) begin
            @(negedge clk);
            check("acc_psel", psel, 1);
            check("acc_penable", penable, 1);
            check("acc_paddr", paddr, al);
            check("acc_pwrite", pwrite, wr);
            check("acc_pwdata", pwdata, exp_wd);
            check("acc_pstrb", pstrb, exp_strb);
            check("acc_pprot", pprot, prot);
            check("acc_resp_valid", resp_valid, 0);
            if (w == waits) begin
                pready  = 1'b1;
                pslverr = err;
                prdata  = err ? err_word(al) : (wr ? $urandom : slave_mem[idx]);
            end else begin
                pready  = 1'b0;
                pslverr = 1'($urandom);
                prdata  = $urandom;
            end
        end

        // RESP
        @(negedge clk);
        pready  = 1'($urandom);
        pslverr = 1'($urandom);
        prdata  = $urandom;
        check("resp_psel", psel, 0);
        check("resp_penable", penable, 0);
        check("resp_valid", resp_valid, 1);
        check("resp_rdata", resp_rdata, exp_rd);
        check("resp_err", resp_err, err);
        check("resp_req_ready", req_ready, 0);
        for (int h = 0; h < hold; h++) begin
            req_valid  = 1'b1;
            req_addr   = $urandom;
            resp_ready = 1'b0;
            @(negedge clk);
            check("hold_resp_valid", resp_valid, 1);
            check("hold_rdata", resp_rdata, exp_rd);
            check("hold_err", resp_err, err);
            check("hold_req_ready", req_ready, 0);
            check("hold_psel", psel, 0);
        end
        resp_ready = 1'b1;
        req_valid  = 1'b0;
        @(negedge clk);
        resp_ready = 1'b0;
        check("done_resp_valid", resp_valid, 0);
        check("done_req_ready", req_ready, 1);
        check("done_busy", busy, 0);
        check("done_psel", psel, 0);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            slave_mem[i] = 32'h0;
            ref_mem[i]   = 32'h0;
        end
        preset     = 1'b1;
        req_valid  = 1'b0;
        req_addr   = 32'h0;
        req_write  = 1'b0;
        req_wdata  = 32'h0;
        req_strb   = 4'h0;
        req_prot   = 3'h0;
        resp_ready = 1'b0;
        pready     = 1'b0;
        prdata     = 32'h0;
        pslverr    = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_req_ready", req_ready, 1);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_rdata", resp_rdata, 0);
        check("rst_resp_err", resp_err, 0);
        check("rst_busy", busy, 0);
        check("rst_psel", psel, 0);
        check("rst_penable", penable, 0);
        check("rst_paddr", paddr, 0);
        check("rst_pwdata", pwdata, 0);
        check("rst_pstrb", pstrb, 0);
        check("rst_pwrite", pwrite, 0);
        check("rst_pprot", pprot, 0);
        preset = 1'b0;
        @(negedge clk);

        // Zero-wait write, then read back with three wait states.
        run_txn(32'h4, 1'b1, 32'hDEAD_BEEF, 4'hF, 3'h2, 0, 0);
        check("slave_word1", slave_mem[1], 32'hDEAD_BEEF);
        run_txn(32'h6, 1'b0, 32'h0, 4'h0, 3'h1, 3, 0);
        // Out-of-range read reports the slave error.
        run_txn(32'h40, 1'b0, 32'h0, 4'h0, 3'h0, 1, 0);
        // Full write, partial write under response back-pressure, read back.
        run_txn(32'h8, 1'b1, 32'h1122_3344, 4'hF, 3'h0, 0, 0);
        run_txn(32'hA, 1'b1, 32'h0000_AB00, 4'h2, 3'h5, 1, 5);
        run_txn(32'h8, 1'b0, 32'h0, 4'h0, 3'h0, 0, 0);
        check("partial_word", slave_mem[2], 32'h1122_AB44);

        // Reset during ACCESS discards the transfer.
        req_valid = 1'b1;
        req_addr  = 32'hC;
        req_write = 1'b0;
        pready    = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("abort_in_access", penable, 1);
        preset = 1'b1;
        @(negedge clk);
        preset = 1'b0;
        check("abort_psel", psel, 0);
        check("abort_penable", penable, 0);
        check("abort_resp_valid", resp_valid, 0);
        check("abort_req_ready", req_ready, 1);
        check("abort_busy", busy, 0);
        pready     = 1'b1;
        resp_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("abort_no_resp", resp_valid, 0);
            check("abort_no_psel", psel, 0);
        end
        pready     = 1'b0;
        resp_ready = 1'b0;

        // Random traffic against the reference memory.
        for (int t = 0; t < 60; t++) begin
            run_txn(32'($urandom_range(0, 'h4F)), 1'($urandom),
                    $urandom, 4'($urandom), 3'($urandom),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end
        for (int i = 0; i < 16; i++)
            check($sformatf("final_mem%0d", i), slave_mem[i], ref_mem[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
